// File: rtl/csa_seq_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential carry-save multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REDUCE  = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Number of REDUCE cycles: one per group of rows.
  function automatic int step_count(input int width, input int rows);
    return width / rows;
  endfunction

  // Step-counter width, $clog2(N), kept at least one bit so N=1 still has a counter.
  function automatic int step_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_seq_multiplier_csa_row.sv
// One row of independent full adders: compresses three vectors into a
// sum/carry pair. The carry is pre-shifted into its weight and the bit
// leaving the top is dropped, so all arithmetic is modulo 2^W.
module csa_row #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] cin,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_fa
      assign sum[gi] = x[gi] ^ y[gi] ^ cin[gi];
      assign maj[gi] = (x[gi] & y[gi]) | (x[gi] & cin[gi]) | (y[gi] & cin[gi]);
    end
  endgenerate

  assign carry = maj << 1;

endmodule

// File: rtl/csa_seq_multiplier.sv
// Sequential carry-save multiplier: ROWS_PER_CYCLE partial-product rows are
// folded into a (sum, carry) pair each clock, then one carry-propagate add
// yields the 2*WIDTH product. Valid/ready handshakes on both sides.
// Optional macro CSA_SIGNED_EN adds the signed_mode input (Baugh-Wooley rows).
module csa_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef CSA_SIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW     = 2 * WIDTH;
  localparam int N      = step_count(WIDTH, ROWS_PER_CYCLE);
  localparam int STEP_W = step_bits(N);
  localparam int IDX_W  = $clog2(WIDTH);

  // Baugh-Wooley correction constants at bit WIDTH and bit 2*WIDTH-1.
  localparam logic [PW-1:0] BW_ONE   = PW'(1);
  localparam logic [PW-1:0] BW_CONST = (BW_ONE << WIDTH) | (BW_ONE << (PW - 1));

  generate
    if (WIDTH < 4 || WIDTH > 64 || ROWS_PER_CYCLE < 1 ||
        (WIDTH % ROWS_PER_CYCLE) != 0) begin : g_bad_params
      $error("csa_seq_multiplier: WIDTH must be 4..64 and divisible by ROWS_PER_CYCLE");
    end
  endgenerate

  state_t              state_reg;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [PW-1:0]       sum_reg;
  logic [PW-1:0]       carry_reg;
  logic [STEP_W-1:0]   step_reg;
  logic                signed_q;

  // Carry-save chain through this cycle's rows.
  logic [PW-1:0] s_chain [ROWS_PER_CYCLE+1];
  logic [PW-1:0] c_chain [ROWS_PER_CYCLE+1];

  assign s_chain[0] = sum_reg;
  assign c_chain[0] = carry_reg;

`ifdef CSA_SIGNED_EN
  logic signed_reg;
  assign signed_q = signed_reg;
`else
  assign signed_q = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < ROWS_PER_CYCLE; gi++) begin : g_row
      logic [IDX_W-1:0] row_idx;
      logic [WIDTH-1:0] row_bits;
      logic [PW-1:0]    pp;

      assign row_idx = IDX_W'(step_reg) * IDX_W'(ROWS_PER_CYCLE) + IDX_W'(gi);

      // Build partial-product row row_idx; signed rows invert the MSB row /
      // MSB column (the corner bit is in both, so it stays true) and row 0
      // carries the correction constants in its otherwise-empty upper bits.
      always_comb begin
        row_bits = a_reg & {WIDTH{b_reg[row_idx]}};
        if (signed_q) begin
          if (row_idx == IDX_W'(WIDTH - 1)) begin
            row_bits = row_bits ^ {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            row_bits = row_bits ^ {1'b1, {(WIDTH-1){1'b0}}};
          end
        end
        pp = {{WIDTH{1'b0}}, row_bits} << row_idx;
        if (signed_q && (row_idx == '0)) begin
          pp = pp | BW_CONST;
        end
      end

      csa_row #(.W(PW)) u_csa_row (
        .x     (s_chain[gi]),
        .y     (c_chain[gi]),
        .cin   (pp),
        .sum   (s_chain[gi+1]),
        .carry (c_chain[gi+1])
      );
    end
  endgenerate

  // Control FSM and datapath registers; all handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= '0;
      step_reg  <= '0;
`ifdef CSA_SIGNED_EN
      signed_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg     <= a;
            b_reg     <= b;
`ifdef CSA_SIGNED_EN
            signed_reg <= signed_mode;
`endif
            sum_reg   <= '0;
            carry_reg <= '0;
            step_reg  <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= REDUCE;
          end
        end
        REDUCE: begin
          sum_reg   <= s_chain[ROWS_PER_CYCLE];
          carry_reg <= c_chain[ROWS_PER_CYCLE];
          step_reg  <= step_reg + STEP_W'(1);
          if (step_reg == STEP_W'(N - 1)) begin
            state_reg <= RESOLVE;
          end
        end
        RESOLVE: begin
          product   <= sum_reg + carry_reg;
          out_valid <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Directed bench for csa_seq_multiplier: three instances
// (0: WIDTH=32 R=1, 1: WIDTH=8 R=1, 2: WIDTH=16 R=4) sharing clock and reset.
module tb_csa_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic iv   [3];
  logic ordy [3];
  logic ir   [3];
  logic ov   [3];
  logic bz   [3];

  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [63:0] p32;
  logic [15:0] p8;
  logic [31:0] p16;
`ifdef CSA_SIGNED_EN
  logic sm;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  csa_seq_multiplier #(.WIDTH(32), .ROWS_PER_CYCLE(1)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a32), .b(b32),
`ifdef CSA_SIGNED_EN
    .signed_mode(sm),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .product(p32), .busy(bz[0])
  );

  csa_seq_multiplier #(.WIDTH(8), .ROWS_PER_CYCLE(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a8), .b(b8),
`ifdef CSA_SIGNED_EN
    .signed_mode(sm),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .product(p8), .busy(bz[1])
  );

  csa_seq_multiplier #(.WIDTH(16), .ROWS_PER_CYCLE(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a16), .b(b16),
`ifdef CSA_SIGNED_EN
    .signed_mode(sm),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .product(p16), .busy(bz[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_prod(input int sel);
    case (sel)
      0:       return p32;
      1:       return {48'd0, p8};
      default: return {32'd0, p16};
    endcase
  endfunction

  task automatic set_ops(input int sel, input logic [63:0] x, input logic [63:0] y);
    case (sel)
      0:       begin a32 = x[31:0]; b32 = y[31:0]; end
      1:       begin a8  = x[7:0];  b8  = y[7:0];  end
      default: begin a16 = x[15:0]; b16 = y[15:0]; end
    endcase
  endtask

  // Handshake one operand pair, then wait (bounded) for out_valid.
  // lat counts cycles from the handshake cycle to the first out_valid cycle.
  // With poke set, in_valid is re-asserted with junk operands while busy.
  task automatic do_op(input int sel, input logic [63:0] x, input logic [63:0] y,
                       input bit poke, output logic [63:0] prod, output int lat);
    @(negedge clk);
    check($sformatf("in_ready_pre_op%0d", sel), 64'(ir[sel]), 64'd1);
    set_ops(sel, x, y);
    iv[sel] = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      iv[sel] = 1'b0;
      if (ov[sel]) break;
      if (lat > 200) begin
        n_cmp++;
        n_bad++;
        $error("FAIL timeout_op%0d: observed no out_valid required out_valid within 200 cycles", sel);
        break;
      end
      if (poke) begin
        check("busy_in_ready_low", 64'(ir[sel]), 64'd0);
        check("busy_high", 64'(bz[sel]), 64'd1);
        set_ops(sel, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        iv[sel] = 1'b1;
      end
    end
    prod = get_prod(sel);
    $display("op inst=%0d a=0x%0h b=0x%0h product=0x%0h latency=%0d", sel, x, y, prod, lat);
  endtask

  initial begin
    logic [63:0] prod;
    logic [31:0] exp_q [$];
    int lat;
    int sent;
    int got;
    bit seen;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    a32 = '0; b32 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
`ifdef CSA_SIGNED_EN
    sm = 1'b0;
`endif

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_in_ready%0d", s),  64'(ir[s]), 64'd1);
      check($sformatf("rst_out_valid%0d", s), 64'(ov[s]), 64'd0);
      check($sformatf("rst_busy%0d", s),      64'(bz[s]), 64'd0);
      check($sformatf("rst_product%0d", s),   get_prod(s), 64'd0);
    end
    rst_n = 1'b1;

    // 32-bit all-ones: latency N+2 = 34.
    do_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, prod, lat);
    check("ones32_product", prod, 64'hFFFF_FFFE_0000_0001);
    check("ones32_latency", 64'(lat), 64'd34);

    // Zero multiplicand on 16/4: full latency 6, in_valid pokes ignored.
    do_op(2, 64'h0, 64'hAB, 1'b1, prod, lat);
    check("zero16_product", prod, 64'h0);
    check("zero16_latency", 64'(lat), 64'd6);
    repeat (3) @(negedge clk);
    check("zero16_no_extra_valid", 64'(ov[2]), 64'd0);
    check("zero16_idle_ready", 64'(ir[2]), 64'd1);

    // Backpressure on 8/1: 13*11 held for 20 cycles.
    ordy[1] = 1'b0;
    do_op(1, 64'd13, 64'd11, 1'b0, prod, lat);
    check("bp_product", prod, 64'h008F);
    check("bp_latency", 64'(lat), 64'd10);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(ov[1]), 64'd1);
      check("bp_hold_product", get_prod(1), 64'h008F);
      check("bp_hold_in_ready", 64'(ir[1]), 64'd0);
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(ov[1]), 64'd0);
    check("bp_release_in_ready", 64'(ir[1]), 64'd1);
    check("bp_release_busy", 64'(bz[1]), 64'd0);

    // Reset during REDUCE step 3 of 0x55*0x33 aborts the operation.
    @(negedge clk);
    set_ops(1, 64'h55, 64'h33);
    iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 64'(bz[1]), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready", 64'(ir[1]), 64'd1);
    check("abort_out_valid", 64'(ov[1]), 64'd0);
    check("abort_busy", 64'(bz[1]), 64'd0);
    check("abort_product", get_prod(1), 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ov[1]) seen = 1'b1;
    end
    check("abort_never_presented", 64'(seen), 64'd0);
    do_op(1, 64'd2, 64'd3, 1'b0, prod, lat);
    check("after_abort_product", prod, 64'd6);
    check("after_abort_latency", 64'(lat), 64'd10);

`ifdef CSA_SIGNED_EN
    sm = 1'b1;
    do_op(1, 64'hFF, 64'h02, 1'b0, prod, lat);
    check("signed_m1x2", prod, 64'hFFFE);
    do_op(1, 64'h80, 64'h80, 1'b0, prod, lat);
    check("signed_m128sq", prod, 64'h4000);
    sm = 1'b0;
    do_op(1, 64'hFF, 64'h02, 1'b0, prod, lat);
    check("unsigned_255x2", prod, 64'h01FE);
    do_op(1, 64'h80, 64'h80, 1'b0, prod, lat);
    check("unsigned_128sq", prod, 64'h4000);
`endif

    // Random sweep on 16/4 with random in_valid / out_ready and a FIFO scoreboard.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 80000 && (sent < 2000 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      iv[2]   = (sent < 2000) && ($urandom_range(0, 1) == 1);
      a16     = 16'($urandom);
      b16     = 16'($urandom);
      ordy[2] = ($urandom_range(0, 3) != 0);
      if (iv[2] && ir[2]) begin
        exp_q.push_back(32'(a16) * 32'(b16));
        sent++;
      end
      if (ov[2] && ordy[2]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL rand_duplicate: observed extra product 0x%0h required none", p16);
        end else begin
          check("rand_product", {32'd0, p16}, {32'd0, exp_q.pop_front()});
          got++;
        end
      end
    end
    iv[2]   = 1'b0;
    ordy[2] = 1'b1;
    $display("random sweep sent=%0d received=%0d", sent, got);
    check("rand_sent", 64'(sent), 64'd2000);
    check("rand_received", 64'(got), 64'(sent));
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
